parity_tx_arbiter: RTL and testbench

Shares one parity generator and one serial line between two requesters. A round-robin arbiter grants one DATA_W-bit word at a time and computes its parity. A framing FSM then shifts out the frame start, data LSB-first, parity, stop. The block sits between local producers and the serial TX pin.

---
 rtl/parity_tx_pkg.sv | 15 +
 rtl/parity_gen_n.sv | 12 +
 rtl/parity_tx_arbiter.sv | 167 ++++++++++++++++
 tb/tb_parity_tx_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/parity_tx_pkg.sv
// Shared types and line levels for the parity TX arbiter.
package parity_tx_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/parity_gen_n.sv
// Combinational parity of one DATA_W-bit word; ODD_PARITY flips the sense.
module parity_gen_n #(
  parameter int DATA_W     = 4,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic [DATA_W-1:0] data_i,
  output logic              parity_o
);

  assign parity_o = (^data_i) ^ ODD_PARITY;

endmodule

// File: rtl/parity_tx_arbiter.sv
// Round-robin arbiter feeding one parity generator and one serial framer.
// Optional frame counter output enabled by PARITY_TX_FRAME_CNT_EN.
module parity_tx_arbiter
  import parity_tx_pkg::*;
#(
  parameter int DATA_W     = 4,
  parameter int BAUD_DIV   = 4,
  parameter int ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              grant_id,
`ifdef PARITY_TX_FRAME_CNT_EN
  output logic [7:0]        frame_cnt,
`endif
  output logic              frame_done
);

  localparam int BAUD_W = cnt_w(BAUD_DIV);
  localparam int BIT_W  = cnt_w(DATA_W);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam bit ODD = (ODD_PARITY != 0);

  state_e              state_q;
  logic [BAUD_W-1:0]   baud_q;
  logic [BIT_W-1:0]    bit_q;
  logic [DATA_W-1:0]   shift_q;
  logic                par_q;
  logic                grant_q;
  logic                last_grant_q;
  logic                busy_q;
  logic                tx_q;
  logic                done_q;

  logic                idle;
  logic                sel;
  logic                accept;
  logic                bit_end;
  logic                par_w;
  logic [DATA_W-1:0]   sel_data;
  logic [DATA_W-1:0]   shift_nx;

  // Both valid: the requester that did not win last time goes next.
  assign idle       = (state_q == IDLE);
  assign sel        = req1_valid && (!req0_valid || !last_grant_q);
  assign sel_data   = sel ? req1_data : req0_data;
  assign req0_ready = rst_n && idle && req0_valid && !sel;
  assign req1_ready = rst_n && idle && req1_valid && sel;
  assign accept     = req0_ready || req1_ready;
  assign bit_end    = (baud_q == BAUD_LAST);
  assign shift_nx   = shift_q >> 1;

  parity_gen_n #(
    .DATA_W     (DATA_W),
    .ODD_PARITY (ODD)
  ) u_par (
    .data_i   (sel_data),
    .parity_o (par_w)
  );

  // tx_q is loaded together with the state change, so it always shows the
  // level of the bit currently being timed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      baud_q       <= '0;
      bit_q        <= '0;
      shift_q      <= '0;
      par_q        <= 1'b0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      busy_q       <= 1'b0;
      tx_q         <= IDLE_LEVEL;
      done_q       <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            shift_q      <= sel_data;
            par_q        <= par_w;
            grant_q      <= sel;
            last_grant_q <= sel;
            busy_q       <= 1'b1;
            baud_q       <= '0;
            tx_q         <= START_LEVEL;
            state_q      <= START;
          end
        end
        START: begin
          if (bit_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            baud_q  <= '0;
            shift_q <= shift_nx;
            if (bit_q == BIT_LAST) begin
              tx_q    <= par_q;
              state_q <= PARITY;
            end else begin
              bit_q <= bit_q + 1'b1;
              tx_q  <= shift_nx[0];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            baud_q  <= '0;
            tx_q    <= STOP_LEVEL;
            done_q  <= (BAUD_LAST == '0);
            state_q <= STOP;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            baud_q  <= '0;
            busy_q  <= 1'b0;
            tx_q    <= IDLE_LEVEL;
            state_q <= IDLE;
          end else begin
            baud_q <= baud_q + 1'b1;
            // Look one clock ahead so the pulse lands on the final stop clock.
            done_q <= ((baud_q + 1'b1) == BAUD_LAST);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef PARITY_TX_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= '0;
    else if (done_q) frame_cnt_q <= frame_cnt_q + 8'd1;
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign tx_out     = tx_q;
  assign busy       = busy_q;
  assign grant_id   = grant_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_parity_tx_arbiter.sv
// Directed bench: default instance (even, BAUD_DIV=4) and a fast odd-parity one.
module tb_parity_tx_arbiter;

  logic clk;
  logic a_rst_n, b_rst_n;
  logic a_v0, a_v1, a_r0, a_r1, a_tx, a_busy, a_gid, a_done;
  logic b_v0, b_v1, b_r0, b_r1, b_tx, b_busy, b_gid, b_done;
  logic [3:0] a_d0, a_d1, b_d0, b_d1;
`ifdef PARITY_TX_FRAME_CNT_EN
  logic [7:0] a_fcnt, b_fcnt;
`endif

  int checks = 0;
  int errors = 0;

  parity_tx_arbiter #(.DATA_W(4), .BAUD_DIV(4), .ODD_PARITY(0)) dut_a (
    .clk(clk), .rst_n(a_rst_n),
    .req0_valid(a_v0), .req0_data(a_d0), .req0_ready(a_r0),
    .req1_valid(a_v1), .req1_data(a_d1), .req1_ready(a_r1),
    .tx_out(a_tx), .busy(a_busy), .grant_id(a_gid),
`ifdef PARITY_TX_FRAME_CNT_EN
    .frame_cnt(a_fcnt),
`endif
    .frame_done(a_done)
  );

  parity_tx_arbiter #(.DATA_W(4), .BAUD_DIV(1), .ODD_PARITY(1)) dut_b (
    .clk(clk), .rst_n(b_rst_n),
    .req0_valid(b_v0), .req0_data(b_d0), .req0_ready(b_r0),
    .req1_valid(b_v1), .req1_data(b_d1), .req1_ready(b_r1),
    .tx_out(b_tx), .busy(b_busy), .grant_id(b_gid),
`ifdef PARITY_TX_FRAME_CNT_EN
    .frame_cnt(b_fcnt),
`endif
    .frame_done(b_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {ready1, ready0, tx, busy, grant_id, frame_done}
  function automatic logic [5:0] sample(input int w);
    if (w != 0) return {b_r1, b_r0, b_tx, b_busy, b_gid, b_done};
    return {a_r1, a_r0, a_tx, a_busy, a_gid, a_done};
  endfunction

  task automatic flip(input int w);
    if (w != 0) begin b_d0 = ~b_d0; b_d1 = ~b_d1; end
    else begin a_d0 = ~a_d0; a_d1 = ~a_d1; end
  endtask

  // Called on a negedge with the winning request already presented.
  // pat lists the 7 line bits in send order, pat[6] first (start bit).
  task automatic frame(input int w, input logic g, input logic [6:0] pat);
    int bd;
    int len;
    logic [5:0] o;
    bd  = (w != 0) ? 1 : 4;
    len = 7 * bd;
    #1 o = sample(w);
    check("accept_ready", 8'(o[5:4]), g ? 8'd2 : 8'd1);
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      if (k == 2 || k == len - 1) flip(w);
      o = sample(w);
      check("tx_bit", 8'(o[3]), 8'(pat[6 - (k - 1) / bd]));
      check("frame_done", 8'(o[0]), 8'(k == len));
      check("busy", 8'(o[2]), 8'd1);
      check("ready_while_busy", 8'(o[5:4]), 8'd0);
      if (k == 1) check("grant_id", 8'(o[1]), 8'(g));
    end
    @(negedge clk);
    o = sample(w);
    check("idle_busy", 8'(o[2]), 8'd0);
    check("idle_tx", 8'(o[3]), 8'd1);
    check("idle_done", 8'(o[0]), 8'd0);
  endtask

  initial begin
    int nd;
    int cyc;
    a_rst_n = 1'b0; b_rst_n = 1'b0;
    a_v0 = 1'b1; a_v1 = 1'b0; a_d0 = 4'h0; a_d1 = 4'h0;
    b_v0 = 1'b0; b_v1 = 1'b0; b_d0 = 4'h0; b_d1 = 4'h0;

    // Reset state, with a request pending that must not be acknowledged.
    repeat (2) @(negedge clk);
    check("rst_tx", 8'(a_tx), 8'd1);
    check("rst_busy", 8'(a_busy), 8'd0);
    check("rst_gid", 8'(a_gid), 8'd0);
    check("rst_done", 8'(a_done), 8'd0);
    check("rst_ready", 8'({a_r1, a_r0}), 8'd0);
    check("rst_b_tx", 8'(b_tx), 8'd1);
`ifdef PARITY_TX_FRAME_CNT_EN
    check("rst_fcnt", a_fcnt, 8'd0);
`endif
    a_v0 = 1'b0;
    @(negedge clk);
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    @(negedge clk);

    // Single words: 1011 even -> parity 1; req1 word 0110 -> parity 0.
    a_v0 = 1'b1; a_d0 = 4'hB;
    frame(0, 1'b0, 7'b0110111);
    a_v0 = 1'b0; a_v1 = 1'b1; a_d1 = 4'h6;
    frame(0, 1'b1, 7'b0011001);
    a_v1 = 1'b0;

    // Abort a req0 frame 10 clocks in (data bit 1 of 1001 is 0 on the line).
    a_v0 = 1'b1; a_d0 = 4'h9;
    repeat (10) @(negedge clk);
    check("mid_tx", 8'(a_tx), 8'd0);
    check("mid_busy", 8'(a_busy), 8'd1);
    a_rst_n = 1'b0;
    #1;
    check("abort_tx", 8'(a_tx), 8'd1);
    check("abort_busy", 8'(a_busy), 8'd0);
    check("abort_done", 8'(a_done), 8'd0);
    a_v0 = 1'b1; a_v1 = 1'b1; a_d0 = 4'h3; a_d1 = 4'hC;
    #1;
    check("abort_ready", 8'({a_r1, a_r0}), 8'd0);
    @(negedge clk);
    a_rst_n = 1'b1;

    // Both held valid: req0 first after reset, then strict alternation.
    frame(0, 1'b0, 7'b0110001);
    frame(0, 1'b1, 7'b0001101);
    frame(0, 1'b0, 7'b0110001);
    frame(0, 1'b1, 7'b0001101);
    a_v0 = 1'b0; a_v1 = 1'b0;

    // Odd parity, one clock per bit, back-to-back req1 words.
    b_v1 = 1'b1; b_d1 = 4'h0;
    frame(1, 1'b1, 7'b0000011);
    b_d1 = 4'hF;
    frame(1, 1'b1, 7'b0111111);
    b_v1 = 1'b0; b_v0 = 1'b1; b_d0 = 4'h5;
    frame(1, 1'b0, 7'b0101011);
    b_v0 = 1'b0;

`ifdef PARITY_TX_FRAME_CNT_EN
    check("a_fcnt", a_fcnt, 8'd4);
    b_rst_n = 1'b0;
    #1 check("b_fcnt_rst", b_fcnt, 8'd0);
    @(negedge clk);
    b_rst_n = 1'b1;
    b_v1 = 1'b1; b_d1 = 4'h5;
    nd = 0; cyc = 0;
    while (nd < 257 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (b_done) nd++;
    end
    b_v1 = 1'b0;
    check("frames_seen_257", 8'(nd == 257), 8'd1);
    repeat (3) @(negedge clk);
    check("b_fcnt_wrap", b_fcnt, 8'd1);
    check("b_idle_after", 8'(b_busy), 8'd0);
`else
    nd = 0; cyc = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
